// File: rtl/decoder_scan_n_if.sv
// Load/select bundle for decoder_scan_n: load handshake in, one-hot select and status out.
interface decoder_scan_n_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned OUTS = 2 ** N;

  logic            en;
  logic            mode;
  logic            load_valid;
  logic [N-1:0]    load_idx;
  logic            load_ready;
  logic [OUTS-1:0] o;
  logic [N-1:0]    idx;
  logic            wrap;

  modport master (
    output en, mode, load_valid, load_idx,
    input  load_ready, o, idx, wrap
  );

  modport slave (
    input  en, mode, load_valid, load_idx,
    output load_ready, o, idx, wrap
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder; HOLD shows a loaded index, SCAN walks all lines
// dwelling DWELL cycles on each and pulses wrap when stepping from the top line to 0.
module decoder_scan_n #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scan_n_if.slave   bus
);
  localparam int unsigned OUTS = 2 ** N;
  localparam int unsigned CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OUTS-1:0] o_q, o_d;
  logic            wrap_q, wrap_d;
  logic            fire;
  logic            last;

  assign bus.load_ready = bus.en;
  assign fire           = bus.load_valid && bus.en;
  assign last           = (cnt_q == CW'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state: en low wins, then a load beats a dwell step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fire) begin
            idx_d   = bus.load_idx;
            cnt_d   = '0;
            state_d = bus.mode ? S_SCAN : S_HOLD;
          end
        end
        S_HOLD: begin
          if (fire) idx_d = bus.load_idx;
          if (bus.mode) begin
            state_d = S_SCAN;
            cnt_d   = '0;
          end
        end
        S_SCAN: begin
          if (!bus.mode) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            if (fire) idx_d = bus.load_idx;
          end else if (fire) begin
            idx_d = bus.load_idx;
            cnt_d = '0;
          end else if (last) begin
            idx_d  = idx_q + N'(1);
            cnt_d  = '0;
            wrap_d = (idx_q == N'(OUTS - 1));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Select is derived from the next index so o and idx never skew.
    o_d = (state_d == S_IDLE) ? '0 : (OUTS'(1) << idx_d);
  end

  assign bus.o    = o_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n: four parameterisations share one random stimulus
// stream and are compared every cycle against a behavioural model, plus directed scenarios.
module tb_decoder_scan_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, mode = 1'b0, lv = 1'b0;
  logic [3:0] li = 4'd0;

  always #5 clk = ~clk;

  decoder_scan_n_if #(.N(3)) i0 ();
  decoder_scan_n_if #(.N(1)) i1 ();
  decoder_scan_n_if #(.N(2)) i2 ();
  decoder_scan_n_if #(.N(4)) i3 ();

  assign i0.en = en; assign i0.mode = mode; assign i0.load_valid = lv; assign i0.load_idx = li[2:0];
  assign i1.en = en; assign i1.mode = mode; assign i1.load_valid = lv; assign i1.load_idx = li[0];
  assign i2.en = en; assign i2.mode = mode; assign i2.load_valid = lv; assign i2.load_idx = li[1:0];
  assign i3.en = en; assign i3.mode = mode; assign i3.load_valid = lv; assign i3.load_idx = li;

  decoder_scan_n #(.N(3), .DWELL(4)) u0 (.clk(clk), .rst(rst), .bus(i0));
  decoder_scan_n #(.N(1), .DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  decoder_scan_n #(.N(2), .DWELL(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
  decoder_scan_n #(.N(4), .DWELL(1)) u3 (.clk(clk), .rst(rst), .bus(i3));

  logic [15:0] d_o   [4];
  logic [3:0]  d_idx [4];
  logic        d_wrap[4];
  logic        d_rdy [4];
  assign d_o[0] = 16'(i0.o); assign d_idx[0] = 4'(i0.idx); assign d_wrap[0] = i0.wrap; assign d_rdy[0] = i0.load_ready;
  assign d_o[1] = 16'(i1.o); assign d_idx[1] = 4'(i1.idx); assign d_wrap[1] = i1.wrap; assign d_rdy[1] = i1.load_ready;
  assign d_o[2] = 16'(i2.o); assign d_idx[2] = 4'(i2.idx); assign d_wrap[2] = i2.wrap; assign d_rdy[2] = i2.load_ready;
  assign d_o[3] = 16'(i3.o); assign d_idx[3] = 4'(i3.idx); assign d_wrap[3] = i3.wrap; assign d_rdy[3] = i3.load_ready;

  int outs_a[4] = '{8, 2, 4, 16};
  int dw_a  [4] = '{4, 1, 2, 1};

  // Model: m_st 0=idle 1=hold 2=scan; m_pos counts cycles spent on the current line.
  int m_st[4], m_idx[4], m_pos[4];
  bit m_wrap[4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_pos[k] = 0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int lidx;
    lidx = int'(li) % outs_a[k];
    m_wrap[k] = 1'b0;
    if (!en) begin
      m_st[k] = 0; m_pos[k] = 0;
    end else if (m_st[k] == 0) begin
      if (lv) begin m_idx[k] = lidx; m_pos[k] = 0; m_st[k] = mode ? 2 : 1; end
    end else if (m_st[k] == 1) begin
      if (lv) m_idx[k] = lidx;
      if (mode) begin m_st[k] = 2; m_pos[k] = 0; end
    end else if (!mode) begin
      m_st[k] = 1;
      if (lv) m_idx[k] = lidx;
    end else if (lv) begin
      m_idx[k] = lidx; m_pos[k] = 0;
    end else begin
      m_pos[k] = m_pos[k] + 1;
      if (m_pos[k] == dw_a[k]) begin
        m_pos[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % outs_a[k];
        m_wrap[k] = (m_idx[k] == 0);
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_o;
    for (int k = 0; k < 4; k++) begin
      exp_o = (m_st[k] == 0) ? 32'd0 : (32'd1 << m_idx[k]);
      check($sformatf("o[%0d]", k), 32'(d_o[k]), exp_o);
      check($sformatf("idx[%0d]", k), 32'(d_idx[k]), 32'(m_idx[k]));
      check($sformatf("wrap[%0d]", k), 32'(d_wrap[k]), 32'(m_wrap[k]));
      check($sformatf("rdy[%0d]", k), 32'(d_rdy[k]), 32'(en));
      check($sformatf("onehot0[%0d]", k), 32'($onehot0(d_o[k])), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 4; k++) model_step(k);
    #1;
    compare_all();
  endtask

  int wraps[4];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_o", 32'(i0.o), 32'h0);
    check("rst_idx", 32'(i0.idx), 32'h0);
    check("rst_wrap", 32'(i0.wrap), 32'h0);
    rst = 1'b0;

    // HOLD loads
    en = 1'b1; mode = 1'b0; lv = 1'b1; li = 4'd5;
    tick();
    check("hold5_o", 32'(i0.o), 32'h20);
    check("hold5_idx", 32'(i0.idx), 32'd5);
    li = 4'd2;
    tick();
    check("hold2_o", 32'(i0.o), 32'h04);

    // SCAN from 6: 4x 0x40, 4x 0x80, then 0x01 with one wrap
    mode = 1'b1; li = 4'd6;
    tick();
    lv = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      check("scan_o", 32'(i0.o), (c < 4) ? 32'h40 : (c < 8) ? 32'h80 : 32'h01);
      check("scan_wrap", 32'(i0.wrap), (c == 8) ? 32'd1 : 32'd0);
    end
    tick();
    check("wrap_once", 32'(i0.wrap), 32'd0);

    // Load on the last dwell cycle beats the step
    tick(); tick();
    lv = 1'b1; li = 4'd3;
    tick();
    lv = 1'b0;
    check("ld_beats_idx", 32'(i0.idx), 32'd3);
    check("ld_beats_wrap", 32'(i0.wrap), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("ld_dwell_o", 32'(i0.o), (c < 4) ? 32'h08 : 32'h10);
    end

    // en low forces idle, idx held; stays idle until a fire
    en = 1'b0;
    tick();
    check("en0_o", 32'(i0.o), 32'h0);
    check("en0_idx", 32'(i0.idx), 32'd4);
    en = 1'b1;
    repeat (3) begin
      tick();
      check("idle_stay_o", 32'(i0.o), 32'h0);
    end
    lv = 1'b1; li = 4'd1;
    tick();
    lv = 1'b0;
    check("idle_fire_o", 32'(i0.o), 32'h02);

    // Async reset mid-cycle during SCAN
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_o", 32'(i0.o), 32'h0);
    check("arst_idx", 32'(i0.idx), 32'h0);
    check("arst_wrap", 32'(i0.wrap), 32'h0);
    tick();
    #3;
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("post_rst_o", 32'(i0.o), 32'h0);
    end

    // Random stimulus across all parameterisations
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      lv = ($urandom_range(0, 5) == 0);
      li = 4'($urandom_range(0, 15));
      tick();
    end

    // Wrap count over an unbroken scan from index 0
    en = 1'b0; lv = 1'b0;
    tick();
    en = 1'b1; mode = 1'b1; lv = 1'b1; li = 4'd0;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 4; k++) wraps[k] = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int k = 0; k < 4; k++) wraps[k] += int'(d_wrap[k]);
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("wrap_cnt[%0d]", k), 32'(wraps[k]), 32'((200 / dw_a[k]) / outs_a[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
